vec_issue_queue: RTL and testbench
==================================

# vec_issue_queue

Buffers 96-bit vector instruction packets (instruction word + two scalar operands) arriving from the scalar core and presents them in order to the vector dispatch decoder. Holds a per-vector-register busy scoreboard and asserts `valid_instruction` only when the head packet has no RAW or WAW hazard. This block is the stage directly upstream of the dispatch decoder.

## Interface
- `DATA_FROM_SCALAR`, 96: packet width. Instruction word is in `[95:64]`, scalar op 2 in `[63:32]`, scalar op 1 in `[31:0]`.
- `INSTRUCTION_BITS`, 32: instruction word width.
- `FIFO_DEPTH`, 4: number of entries. Must be a power of two and ≥2.
- `NUM_VREGS`, 32: number of vector registers, and the width of the busy vector.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `push_valid` in 1: the scalar core offers a packet.
- `push_data` in `DATA_FROM_SCALAR`: the offered packet.
- `push_ready` out 1: the queue can accept a packet.
- `flush` in 1: synchronous discard of all queued packets.
- `instruction_out` out `DATA_FROM_SCALAR`: the head packet, driven to the decoder's `instruction_in`.
- `valid_instruction` out 1: the head packet is present and hazard-free.
- `ready_vector` in 1: the decoder accepts the packet.
- `wb_valid` in 1: a vector writeback has completed.
- `wb_reg` in 5: the register released by that writeback.
- `busy_vector` out `NUM_VREGS`: scoreboard state, one bit per register.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: current occupancy.

## Operation
- **FIFO**
  - Circular buffer with read and write pointers that are one bit wider than the index.
  - Push occurs when `push_valid && push_ready`. `push_ready = (count < FIFO_DEPTH)`.
  - Pop (issue) occurs when `valid_instruction && ready_vector`.
  - If push and pop happen in the same cycle, `count` is unchanged. The pointers wrap modulo depth.
- **Decode of the head packet** (`instr = head[95:64]`)
  - Opcode `[6:0]`: `1010111` is OP-V, `0000111` is load, `0100111` is store. Any other opcode issues with no hazard checks and no busy set.
  - `vs1 = [19:15]`. It is used only for OP-V with funct3 `[14:12]` in {000, 001, 010}.
  - `vs2 = [24:20]`. It is used for all OP-V, and for load/store only when mop `[27:26]` is 01 or 11 (indexed).
  - `vd = [11:7]`. It is read as a source by stores. It is written by OP-V with funct3≠111 and by loads.
  - `vm = [25]`. `vm=0` reads v0.
- **Hazard rule**
  - The head is blocked if any used source is busy (RAW), or if the `vd` it writes is busy (WAW).
  - OP-V with funct3=111 (vsetvl) is blocked until `busy_vector == 0`.
  - `valid_instruction = !empty && !hazard`.
- **Scoreboard**
  - On issue of a `vd`-writing packet, set `busy[vd]`.
  - On `wb_valid`, clear `busy[wb_reg]`.
  - If set and clear target the same register in the same cycle, the set wins.
  - `wb_valid` to a register that is not busy has no effect.
- **Flush**
  - Pointers and count go to 0 at the next edge, and the packet at the head is not issued that cycle (`valid_instruction` is forced to 0 while `flush=1`).
  - The scoreboard is not cleared.
  - A push in the same cycle as `flush` is dropped.

## Timing
- Reset values: pointers, count and `busy_vector` are 0. `valid_instruction`=0, `push_ready`=1, and `instruction_out` is the contents of entry 0, which is not reset.
- A packet pushed at edge N is visible at the head, and `valid_instruction` can be high, in cycle N+1. Minimum push-to-issue latency is 1 cycle.
- Back-to-back dependent instructions: the consumer is held until the cycle after `wb_valid` for its producer register. With `VEC_ISSUE_BYPASS_EN` it can issue in the same cycle as that `wb_valid`.
- Full queue: `push_ready`=0 even if a pop occurs in the same cycle. There is no same-cycle pass-through.
- Empty queue: `valid_instruction`=0. `instruction_out` is don't-care.
- Asserting `rst` mid-operation clears all state immediately (asynchronous).

## Configuration
- `VEC_ISSUE_BYPASS_EN` defined: the hazard check uses `busy & ~({NUM_VREGS{wb_valid}} & onehot(wb_reg))`. A register being released in the current cycle is treated as free.
- `VEC_ISSUE_BYPASS_EN` undefined: the hazard check uses registered `busy_vector` only. This adds one cycle of dependent-issue latency but removes the combinational path from `wb_valid` to `valid_instruction`.

## Structure
- Package `vec_issue_pkg` contains:
  - opcode constants (`OPC_OPV`, `OPC_LOAD`, `OPC_STORE`);
  - funct3 constants;
  - field bit-position localparams;
  - function `uses_vs1` / `uses_vs2` / `writes_vd` helpers.
- Sub-module `vec_issue_fifo` is the storage plus pointers: push/pop/flush, count, full/empty. The top level holds the decode, hazard check and scoreboard.

## Test plan
- **Single issue:** push OP-V vadd.vv vd=3, vs1=1, vs2=2 into an empty queue → `valid_instruction`=1 in the next cycle. On pop, `busy_vector[3]`=1 and `fifo_count` returns to 0.
- **RAW stall:** vadd vd=3, then vadd vs2=3. The second is held with `valid_instruction`=0. Apply `wb_valid`, `wb_reg`=3 → it issues one cycle later (bypass off) or in the same cycle (bypass on).
- **Full/wrap:** push 4 independent packets with `ready_vector`=0 → `push_ready`=0 and `fifo_count`=4. Pop 4 and push 4 more → the order is preserved across pointer wrap.
- **Same-cycle set/clear:** issue vd=5 while `wb_valid`, `wb_reg`=5 → `busy_vector[5]` remains 1.
- **vsetvl drain:** with `busy_vector[7]`=1, push a funct3=111 packet → it is blocked until reg 7 is released, then issues.
- **Flush/reset:** with 3 entries queued, assert `flush` → `fifo_count`=0 and the busy bits are unchanged. Asserting `rst` mid-stream makes all outputs take their reset values immediately.

Source files
------------

// File: rtl/vec_issue_pkg.sv
// Shared decode constants and field helpers for the vector issue queue.
package vec_issue_pkg;

  localparam int INSTR_W = 32;

  localparam logic [6:0] OPC_OPV   = 7'b1010111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000111;
  localparam logic [6:0] OPC_STORE = 7'b0100111;

  localparam logic [2:0] F3_OPIVV = 3'b000;
  localparam logic [2:0] F3_OPFVV = 3'b001;
  localparam logic [2:0] F3_OPMVV = 3'b010;
  localparam logic [2:0] F3_OPCFG = 3'b111;

  localparam int OPC_LSB = 0;
  localparam int VD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int VS1_LSB = 15;
  localparam int VS2_LSB = 20;
  localparam int VM_BIT  = 25;
  localparam int MOP_LSB = 26;

  typedef enum logic [1:0] {
    CLS_OTHER = 2'd0,
    CLS_OPV   = 2'd1,
    CLS_LOAD  = 2'd2,
    CLS_STORE = 2'd3
  } op_class_e;

  function automatic op_class_e op_class(input logic [INSTR_W-1:0] instr);
    case (instr[OPC_LSB +: 7])
      OPC_OPV:   op_class = CLS_OPV;
      OPC_LOAD:  op_class = CLS_LOAD;
      OPC_STORE: op_class = CLS_STORE;
      default:   op_class = CLS_OTHER;
    endcase
  endfunction

  function automatic logic is_vsetvl(input logic [INSTR_W-1:0] instr);
    is_vsetvl = (op_class(instr) == CLS_OPV) && (instr[F3_LSB +: 3] == F3_OPCFG);
  endfunction

  function automatic logic uses_vs1(input logic [INSTR_W-1:0] instr);
    logic [2:0] f3;
    f3 = instr[F3_LSB +: 3];
    uses_vs1 = (op_class(instr) == CLS_OPV) &&
               ((f3 == F3_OPIVV) || (f3 == F3_OPFVV) || (f3 == F3_OPMVV));
  endfunction

  // Memory ops only read vs2 for the indexed addressing modes.
  function automatic logic uses_vs2(input logic [INSTR_W-1:0] instr);
    logic [1:0] mop;
    mop = instr[MOP_LSB +: 2];
    uses_vs2 = (op_class(instr) == CLS_OPV) ||
               (((op_class(instr) == CLS_LOAD) || (op_class(instr) == CLS_STORE)) &&
                ((mop == 2'b01) || (mop == 2'b11)));
  endfunction

  function automatic logic writes_vd(input logic [INSTR_W-1:0] instr);
    writes_vd = ((op_class(instr) == CLS_OPV) && (instr[F3_LSB +: 3] != F3_OPCFG)) ||
                (op_class(instr) == CLS_LOAD);
  endfunction

  function automatic logic reads_vd(input logic [INSTR_W-1:0] instr);
    reads_vd = (op_class(instr) == CLS_STORE);
  endfunction

  function automatic logic reads_v0(input logic [INSTR_W-1:0] instr);
    reads_v0 = (op_class(instr) != CLS_OTHER) && !instr[VM_BIT];
  endfunction

endpackage

// File: rtl/vec_issue_if.sv
// Scalar-core push side, decoder issue side and writeback/scoreboard signals of the issue queue.
interface vec_issue_if
  import vec_issue_pkg::*;
#(
  parameter int DATA_FROM_SCALAR = 96,
  parameter int FIFO_DEPTH       = 4,
  parameter int NUM_VREGS        = 32
);
  logic                            push_valid;
  logic [DATA_FROM_SCALAR-1:0]     push_data;
  logic                            push_ready;
  logic                            flush;
  logic [DATA_FROM_SCALAR-1:0]     instruction_out;
  logic                            valid_instruction;
  logic                            ready_vector;
  logic                            wb_valid;
  logic [4:0]                      wb_reg;
  logic [NUM_VREGS-1:0]            busy_vector;
  logic [$clog2(FIFO_DEPTH):0]     fifo_count;

  modport master (
    output push_valid, push_data, flush, ready_vector, wb_valid, wb_reg,
    input  push_ready, instruction_out, valid_instruction, busy_vector, fifo_count
  );

  modport slave (
    input  push_valid, push_data, flush, ready_vector, wb_valid, wb_reg,
    output push_ready, instruction_out, valid_instruction, busy_vector, fifo_count
  );
endinterface

// File: rtl/vec_issue_fifo.sv
// Circular packet store with extra-bit pointers; flush discards contents and drops a same-cycle push.
module vec_issue_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign count     = wr_ptr_r - rd_ptr_r;
  assign full      = (count == FULL_CNT);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign head      = mem_r[rd_ptr_r[AW-1:0]];
  assign push_ok_s = push && !full && !flush;
  assign pop_ok_s  = pop && !empty && !flush;

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

  // Packet storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/vec_issue_queue.sv
// In-order vector issue queue with RAW/WAW busy scoreboard in front of the dispatch decoder.
// Optional macro VEC_ISSUE_BYPASS_EN: a same-cycle writeback frees its register for the hazard check.
module vec_issue_queue
  import vec_issue_pkg::*;
#(
  parameter int DATA_FROM_SCALAR = 96,
  parameter int INSTRUCTION_BITS = 32,
  parameter int FIFO_DEPTH       = 4,
  parameter int NUM_VREGS        = 32
) (
  input logic        clk,
  input logic        rst,
  vec_issue_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [NUM_VREGS-1:0] NO_REGS = '0;

  logic [DATA_FROM_SCALAR-1:0] head_s;
  logic [INSTRUCTION_BITS-1:0] instr_s;
  logic [CW-1:0]               count_s;
  logic                        empty_s, full_s, hazard_s, valid_s, issue_s;
  logic [4:0]                  vd_s, vs1_s, vs2_s;
  logic [NUM_VREGS-1:0]        busy_r, busy_eff_s, wb_mask_s, need_mask_s, set_mask_s;

  function automatic logic [NUM_VREGS-1:0] reg_bit(input logic [4:0] r);
    reg_bit    = '0;
    reg_bit[r] = 1'b1;
  endfunction

  vec_issue_fifo #(.WIDTH(DATA_FROM_SCALAR), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.flush),
    .push     (bus.push_valid),
    .push_data(bus.push_data),
    .pop      (issue_s),
    .head     (head_s),
    .count    (count_s),
    .full     (full_s),
    .empty    (empty_s)
  );

  assign instr_s = head_s[DATA_FROM_SCALAR-1 -: INSTRUCTION_BITS];
  assign vd_s    = instr_s[VD_LSB +: 5];
  assign vs1_s   = instr_s[VS1_LSB +: 5];
  assign vs2_s   = instr_s[VS2_LSB +: 5];

  // Hazard check for the head packet; vsetvl waits for the whole scoreboard to drain.
  always_comb begin
    wb_mask_s   = bus.wb_valid ? reg_bit(bus.wb_reg) : NO_REGS;
`ifdef VEC_ISSUE_BYPASS_EN
    busy_eff_s  = busy_r & ~wb_mask_s;
`else
    busy_eff_s  = busy_r;
`endif
    need_mask_s = (uses_vs1(instr_s) ? reg_bit(vs1_s) : NO_REGS) |
                  (uses_vs2(instr_s) ? reg_bit(vs2_s) : NO_REGS) |
                  (reads_v0(instr_s) ? reg_bit(5'd0)  : NO_REGS) |
                  ((writes_vd(instr_s) || reads_vd(instr_s)) ? reg_bit(vd_s) : NO_REGS);
    if (is_vsetvl(instr_s)) hazard_s = |busy_eff_s;
    else                    hazard_s = |(need_mask_s & busy_eff_s);
    valid_s    = !empty_s && !hazard_s && !bus.flush;
    issue_s    = valid_s && bus.ready_vector;
    set_mask_s = (issue_s && writes_vd(instr_s)) ? reg_bit(vd_s) : NO_REGS;
  end

  // Scoreboard: clear on writeback first, so a same-cycle set on the same register wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_r <= '0;
    else     busy_r <= (busy_r & ~wb_mask_s) | set_mask_s;
  end

  assign bus.push_ready        = !full_s;
  assign bus.valid_instruction = valid_s;
  assign bus.instruction_out   = head_s;
  assign bus.busy_vector       = busy_r;
  assign bus.fifo_count        = count_s;
endmodule

// File: tb/tb_vec_issue_queue.sv
// Self-checking bench for vec_issue_queue: directed scenarios plus randomized traffic against a queue model.
module tb_vec_issue_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  vec_issue_if bus ();

  vec_issue_queue dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [95:0] m_q [$];
  logic [31:0] m_busy = 32'h0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Register written by the instruction, or -1.
  function automatic int dest(input logic [31:0] ins);
    if (ins[6:0] == 7'h57 && ins[14:12] != 3'd7) return int'(ins[11:7]);
    if (ins[6:0] == 7'h07) return int'(ins[11:7]);
    return -1;
  endfunction

  function automatic bit blocked(input logic [31:0] ins, input logic [31:0] busy);
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    bit is_v  = (opc == 7'h57);
    bit is_ls = (opc == 7'h07) || (opc == 7'h27);
    bit b = 1'b0;
    if (is_v && f3 == 3'd7) return busy != 32'h0;
    if (!is_v && !is_ls) return 1'b0;
    if (!ins[25]) b |= busy[0];
    if (is_v || ins[26]) b |= busy[ins[24:20]];
    if (is_v && f3 <= 3'd2) b |= busy[ins[19:15]];
    if (opc == 7'h27 || dest(ins) >= 0) b |= busy[ins[11:7]];
    return b;
  endfunction

  // Compare DUT against the model every cycle, then advance the model by the coming edge.
  always @(negedge clk) begin
    logic [31:0] eff;
    bit ev, epr;
    int d;
    if (rst) begin
      m_q.delete();
      m_busy = 32'h0;
      chk("rst_count", bus.fifo_count, 0);
      chk("rst_valid", bus.valid_instruction, 0);
      chk("rst_push_ready", bus.push_ready, 1);
      chk("rst_busy", bus.busy_vector, 0);
    end else begin
      eff = m_busy;
`ifdef VEC_ISSUE_BYPASS_EN
      if (bus.wb_valid) eff[bus.wb_reg] = 1'b0;
`endif
      epr = (m_q.size() < 4);
      ev  = (m_q.size() != 0) && !bus.flush && !blocked(m_q[0][95:64], eff);
      chk("count", bus.fifo_count, m_q.size());
      chk("push_ready", bus.push_ready, epr);
      chk("valid", bus.valid_instruction, ev);
      chk("busy", bus.busy_vector, m_busy);
      if (m_q.size() != 0) chk("head", bus.instruction_out, m_q[0]);
      if (bus.wb_valid) m_busy[bus.wb_reg] = 1'b0;
      if (ev && bus.ready_vector) begin
        d = dest(m_q[0][95:64]);
        if (d >= 0) m_busy[d] = 1'b1;
        void'(m_q.pop_front());
      end
      if (bus.flush) m_q.delete();
      else if (bus.push_valid && epr) m_q.push_back(bus.push_data);
    end
  end

  function automatic logic [31:0] opv(input logic [2:0] f3, input logic [4:0] vd,
                                      input logic [4:0] vs1, input logic [4:0] vs2, input logic vm);
    return {6'b000000, vm, vs2, vs1, f3, vd, 7'b1010111};
  endfunction

  function automatic logic [31:0] other_instr();
    logic [31:0] ins = $urandom();
    ins[6:0] = 7'h13;
    return ins;
  endfunction

  function automatic logic [95:0] pk(input logic [31:0] ins);
    logic [31:0] a = $urandom();
    logic [31:0] b = $urandom();
    return {ins, a, b};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [2:0]  f3_tab [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    logic [6:0]  opc_tab [4] = '{7'h57, 7'h07, 7'h27, 7'h13};
    logic [31:0] ins = $urandom();
    int sel = $urandom_range(0, 9);
    ins[6:0]   = (sel < 6) ? opc_tab[0] : opc_tab[sel - 6 > 3 ? 3 : sel - 6];
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[14:12] = f3_tab[$urandom_range(0, 5)];
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    ins[25]    = ($urandom_range(0, 3) != 0);
    return ins;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      bus.push_valid   = ($urandom_range(0, 9) < 6);
      bus.push_data    = pk(rand_instr());
      bus.ready_vector = ($urandom_range(0, 9) < 7);
      bus.wb_valid     = ($urandom_range(0, 9) < 4);
      bus.wb_reg       = 5'($urandom_range(0, 7));
      bus.flush        = ($urandom_range(0, 49) == 0);
      nxt();
    end
    bus.flush = 1'b0;
  endtask

  logic [95:0] p;
  logic [95:0] fp [4];

  initial begin
    bus.push_valid = 1'b0; bus.push_data = '0; bus.flush = 1'b0;
    bus.ready_vector = 1'b0; bus.wb_valid = 1'b0; bus.wb_reg = 5'd0;
    #2;
    chk("init_count", bus.fifo_count, 0);
    chk("init_push_ready", bus.push_ready, 1);
    chk("init_valid", bus.valid_instruction, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // single issue
    p = pk(opv(3'b000, 5'd3, 5'd1, 5'd2, 1'b1));
    bus.ready_vector = 1'b1; bus.push_valid = 1'b1; bus.push_data = p;
    #2 chk("empty_valid", bus.valid_instruction, 0);
    nxt(); bus.push_valid = 1'b0;
    #2 chk("single_valid", bus.valid_instruction, 1);
    chk("single_count", bus.fifo_count, 1);
    chk("single_head", bus.instruction_out, p);
    nxt();
    #2 chk("single_count0", bus.fifo_count, 0);
    chk("single_busy", bus.busy_vector, 32'h8);

    // RAW stall on v3
    p = pk(opv(3'b000, 5'd4, 5'd0, 5'd3, 1'b1));
    bus.push_valid = 1'b1; bus.push_data = p;
    nxt(); bus.push_valid = 1'b0;
    #2 chk("raw_hold", bus.valid_instruction, 0);
    chk("raw_count", bus.fifo_count, 1);
    nxt(); bus.wb_valid = 1'b1; bus.wb_reg = 5'd3;
`ifdef VEC_ISSUE_BYPASS_EN
    #2 chk("raw_bypass_issue", bus.valid_instruction, 1);
    nxt(); bus.wb_valid = 1'b0;
`else
    #2 chk("raw_hold_wb", bus.valid_instruction, 0);
    nxt(); bus.wb_valid = 1'b0;
    #2 chk("raw_issue", bus.valid_instruction, 1);
    nxt();
`endif
    #2 chk("raw_count0", bus.fifo_count, 0);
    chk("raw_busy", bus.busy_vector, 32'h10);

    // same-cycle set and clear of v5
    p = pk(opv(3'b000, 5'd5, 5'd6, 5'd7, 1'b1));
    bus.push_valid = 1'b1; bus.push_data = p;
    nxt(); bus.push_valid = 1'b0; bus.wb_valid = 1'b1; bus.wb_reg = 5'd5;
    #2 chk("setclr_valid", bus.valid_instruction, 1);
    nxt(); bus.wb_valid = 1'b0;
    #2 chk("setclr_busy", bus.busy_vector, 32'h30);

    // vsetvl waits for the scoreboard to drain
    p = pk(opv(3'b000, 5'd7, 5'd8, 5'd9, 1'b1));
    bus.push_valid = 1'b1; bus.push_data = p;
    nxt(); bus.push_valid = 1'b0;
    nxt();
    #2 chk("v7_busy", bus.busy_vector, 32'hB0);
    p = pk(opv(3'b111, 5'd1, 5'd2, 5'd3, 1'b1));
    bus.push_valid = 1'b1; bus.push_data = p;
    nxt(); bus.push_valid = 1'b0; bus.wb_valid = 1'b1; bus.wb_reg = 5'd4;
    #2 chk("vset_hold4", bus.valid_instruction, 0);
    nxt(); bus.wb_reg = 5'd5;
    #2 chk("vset_hold5", bus.valid_instruction, 0);
    nxt(); bus.wb_reg = 5'd7;
`ifdef VEC_ISSUE_BYPASS_EN
    #2 chk("vset_bypass_issue", bus.valid_instruction, 1);
    nxt(); bus.wb_valid = 1'b0;
`else
    #2 chk("vset_hold7", bus.valid_instruction, 0);
    nxt(); bus.wb_valid = 1'b0;
    #2 chk("vset_issue", bus.valid_instruction, 1);
    nxt();
`endif
    #2 chk("vset_busy", bus.busy_vector, 32'h0);
    chk("vset_count", bus.fifo_count, 0);

    // full queue and order across pointer wrap
    for (int r = 0; r < 2; r++) begin
      bus.ready_vector = 1'b0;
      for (int i = 0; i < 4; i++) begin
        fp[i] = pk(other_instr());
        bus.push_valid = 1'b1; bus.push_data = fp[i];
        nxt();
      end
      bus.push_data = pk(other_instr());
      #2 chk("full_ready", bus.push_ready, 0);
      chk("full_count", bus.fifo_count, 4);
      nxt(); bus.push_valid = 1'b0; bus.ready_vector = 1'b1;
      for (int i = 0; i < 4; i++) begin
        #2 chk("wrap_order", bus.instruction_out, fp[i]);
        chk("wrap_valid", bus.valid_instruction, 1);
        nxt();
      end
      #2 chk("wrap_count0", bus.fifo_count, 0);
    end

    // flush keeps the scoreboard
    p = pk(opv(3'b000, 5'd9, 5'd10, 5'd11, 1'b1));
    bus.push_valid = 1'b1; bus.push_data = p;
    nxt(); bus.push_valid = 1'b0;
    nxt();
    #2 chk("flush_pre_busy", bus.busy_vector, 32'h200);
    bus.ready_vector = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.push_valid = 1'b1; bus.push_data = pk(other_instr());
      nxt();
    end
    bus.push_valid = 1'b0;
    #2 chk("flush_pre_count", bus.fifo_count, 3);
    bus.flush = 1'b1; bus.push_valid = 1'b1; bus.ready_vector = 1'b1;
    #1 chk("flush_valid", bus.valid_instruction, 0);
    nxt(); bus.flush = 1'b0; bus.push_valid = 1'b0;
    #2 chk("flush_count", bus.fifo_count, 0);
    chk("flush_busy", bus.busy_vector, 32'h200);

    for (int r = 0; r < 32; r++) begin
      bus.wb_valid = 1'b1; bus.wb_reg = 5'(r);
      nxt();
    end
    bus.wb_valid = 1'b0;

    rand_cycles(3000);

    // asynchronous reset mid-stream
    bus.ready_vector = 1'b0; bus.wb_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.push_valid = 1'b1; bus.push_data = pk(other_instr());
      nxt();
    end
    bus.push_valid = 1'b0;
    rst = 1'b1;
    #1 chk("async_rst_count", bus.fifo_count, 0);
    chk("async_rst_valid", bus.valid_instruction, 0);
    chk("async_rst_push_ready", bus.push_ready, 1);
    chk("async_rst_busy", bus.busy_vector, 32'h0);
    nxt(); nxt();
    rst = 1'b0;

    rand_cycles(300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
